// File: rtl/fifo_stream_drain_if.sv
// Read-port and output-stream bundle between a sync FIFO, the drain stage and its consumer.
// The master modport is the drain side; the slave modport is the FIFO/consumer side.
interface fifo_stream_drain_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  fifo_shift_out;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_valid;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output fifo_shift_out,
        input  fifo_dout,
        input  fifo_valid,
        input  fifo_empty,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_last
    );

    modport slave (
        input  fifo_shift_out,
        output fifo_dout,
        output fifo_valid,
        output fifo_empty,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_last
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains a sync FIFO into a valid/ready stream through a 2-entry skid buffer,
// tagging every BURST_LEN-th accepted beat with m_last.
module fifo_stream_drain #(
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned READ_LATENCY = 1,
    parameter  int unsigned BURST_LEN    = 16,
    localparam int unsigned CNT_W        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fifo_stream_drain_if.master    bus,
    output logic [CNT_W-1:0]       beat_cnt,
    output logic                   overrun
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [1:0]            occ_q, occ_d;
    logic                  wr_idx_q, wr_idx_d;
    logic                  rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  overrun_q, overrun_d;
    logic                  inflight_q;
    logic                  pop_c;
    logic                  push_c;
    logic                  drop_c;
    logic                  shift_c;

    // Credit check counts the current pop so a full buffer resumes pulling in the same cycle.
    always_comb begin
        pop_c      = (occ_q != 2'd0) && bus.m_ready;
        shift_c    = rst_n && !bus.fifo_empty &&
                     (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_c}));
        drop_c     = bus.fifo_valid && (occ_q == 2'd2) && !pop_c;
        push_c     = bus.fifo_valid && !drop_c;
        occ_d      = occ_q + 2'(push_c) - 2'(pop_c);
        wr_idx_d   = wr_idx_q ^ push_c;
        rd_idx_d   = rd_idx_q ^ pop_c;
        overrun_d  = overrun_q | drop_c;
        beat_cnt_d = beat_cnt_q;
        if (pop_c) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            wr_idx_q   <= 1'b0;
            rd_idx_q   <= 1'b0;
            beat_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            beat_cnt_q <= beat_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_idx_q] <= bus.fifo_dout;
        end
    end

    if (READ_LATENCY != 0) begin : g_inflight
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= shift_c;
            end
        end
    end else begin : g_no_inflight
        assign inflight_q = 1'b0;
    end

    assign bus.fifo_shift_out = shift_c;
    assign bus.m_valid        = (occ_q != 2'd0);
    assign bus.m_data         = mem_q[rd_idx_q];
    assign bus.m_last         = (occ_q != 2'd0) && (beat_cnt_q == LAST_BEAT);
    assign beat_cnt           = beat_cnt_q;
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain: four drain instances, each fed by a small FIFO model.
// 0: latency 1, burst 16 | 1: latency 0 | 2: latency-0 drain on latency-1 FIFO | 3: burst 1.
module tb_fifo_stream_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]        rstn;
    logic [3:0]        rdy;
    int unsigned       tail [4];
    logic [31:0]       fmem [4][256];

    logic [3:0]        so, mv, ml, ovr, emp;
    logic [3:0][31:0]  md, bc;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned DRL = (g == 1 || g == 2) ? 0 : 1;
        localparam int unsigned FRL = (g == 1) ? 0 : 1;
        localparam int unsigned BL  = (g == 3) ? 1 : 16;
        localparam int unsigned CW  = (BL > 1) ? $clog2(BL) : 1;

        fifo_stream_drain_if #(.DATA_WIDTH(32)) bus ();
        logic [CW-1:0] cnt;
        logic          ov;
        int unsigned   head = 0;
        logic          empty;

        fifo_stream_drain #(
            .DATA_WIDTH  (32),
            .READ_LATENCY(DRL),
            .BURST_LEN   (BL)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rstn[g]),
            .bus     (bus),
            .beat_cnt(cnt),
            .overrun (ov)
        );

        assign empty          = (head == tail[g]);
        assign bus.fifo_empty = empty;
        assign bus.m_ready    = rdy[g];

        if (FRL == 1) begin : g_f1
            logic        vq;
            logic [31:0] dq;
            always @(posedge clk) begin
                if (!rstn[g]) begin
                    vq <= 1'b0;
                end else begin
                    vq <= bus.fifo_shift_out && !empty;
                    if (bus.fifo_shift_out && !empty) begin
                        dq   <= fmem[g][head[7:0]];
                        head <= head + 1;
                    end
                end
            end
            assign bus.fifo_valid = vq;
            assign bus.fifo_dout  = dq;
        end else begin : g_f0
            always @(posedge clk) begin
                if (rstn[g] && bus.fifo_shift_out && !empty) head <= head + 1;
            end
            assign bus.fifo_valid = bus.fifo_shift_out && !empty;
            assign bus.fifo_dout  = fmem[g][head[7:0]];
        end

        assign so[g]  = bus.fifo_shift_out;
        assign mv[g]  = bus.m_valid;
        assign ml[g]  = bus.m_last;
        assign md[g]  = bus.m_data;
        assign ovr[g] = ov;
        assign emp[g] = empty;
        assign bc[g]  = 32'(cnt);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int got;
        int cyc;
        rstn = '0;
        rdy  = '0;
        for (int i = 0; i < 4; i++) tail[i] = 0;
        for (int i = 0; i < 40; i++)  fmem[0][i] = 32'(i);
        for (int i = 0; i < 200; i++) fmem[1][i] = 32'(i * 3 + 7);
        for (int i = 0; i < 4; i++)   fmem[2][i] = 32'(32'hA0 + i);
        for (int i = 0; i < 5; i++)   fmem[3][i] = 32'(50 + i);
        tail[0] = 40;
        tail[2] = 4;
        tail[3] = 5;
        tick();
        tick();

        // Reset values while the FIFO already holds data
        chk("rst_valid", 32'(mv[0]), 32'd0);
        chk("rst_last", 32'(ml[0]), 32'd0);
        chk("rst_cnt", bc[0], 32'd0);
        chk("rst_ovr", 32'(ovr[0]), 32'd0);
        chk("rst_shift", 32'(so[0]), 32'd0);

        // Continuous drain of 0..39
        rdy[0]  = 1'b1;
        rstn[0] = 1'b1;
        #1;
        chk("first_pop", 32'(so[0]), 32'd1);
        tick();
        chk("lat_valid0", 32'(mv[0]), 32'd0);
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("cont_valid", 32'(mv[0]), 32'd1);
            chk("cont_data", md[0], 32'(k));
            chk("cont_last", 32'(ml[0]), 32'((k == 15) || (k == 31)));
        end
        tick();
        chk("cont_end_valid", 32'(mv[0]), 32'd0);
        chk("cont_end_cnt", bc[0], 32'd8);
        chk("cont_end_shift", 32'(so[0]), 32'd0);

        // Backpressure after three beats
        rstn[0] = 1'b0;
        tick();
        chk("bp_rst_valid", 32'(mv[0]), 32'd0);
        chk("bp_rst_cnt", bc[0], 32'd0);
        for (int i = 0; i < 10; i++) fmem[0][40 + i] = 32'(i);
        tail[0] = 50;
        #1;
        chk("bp_rst_shift", 32'(so[0]), 32'd0);
        rstn[0] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_pre_data", md[0], 32'(k));
        end
        tick();
        rdy[0] = 1'b0;
        #1;
        chk("bp_stall_shift", 32'(so[0]), 32'd0);
        chk("bp_stall_data", md[0], 32'd3);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("bp_hold_valid", 32'(mv[0]), 32'd1);
            chk("bp_hold_data", md[0], 32'd3);
            chk("bp_hold_shift", 32'(so[0]), 32'd0);
        end
        tick();
        rdy[0] = 1'b1;
        #1;
        chk("bp_resume_shift", 32'(so[0]), 32'd1);
        chk("bp_resume_data", md[0], 32'd3);
        for (int k = 4; k < 10; k++) begin
            tick();
            chk("bp_post_valid", 32'(mv[0]), 32'd1);
            chk("bp_post_data", md[0], 32'(k));
        end
        tick();
        chk("bp_end_valid", 32'(mv[0]), 32'd0);
        chk("bp_end_cnt", bc[0], 32'd10);

        // Reset mid-burst with two words buffered
        rstn[0] = 1'b0;
        for (int i = 0; i < 7; i++) fmem[0][50 + i] = 32'(200 + i);
        tail[0] = 57;
        tick();
        rstn[0] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mid_data", md[0], 32'(200 + k));
        end
        tick();
        chk("mid_head", md[0], 32'd205);
        rdy[0] = 1'b0;
        tick();
        chk("mid_hold_valid", 32'(mv[0]), 32'd1);
        chk("mid_hold_data", md[0], 32'd205);
        chk("mid_hold_cnt", bc[0], 32'd5);
        chk("mid_hold_shift", 32'(so[0]), 32'd0);
        rstn[0] = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(mv[0]), 32'd0);
        chk("mid_rst_cnt", bc[0], 32'd0);
        chk("mid_rst_last", 32'(ml[0]), 32'd0);
        for (int i = 0; i < 16; i++) fmem[0][57 + i] = 32'(300 + i);
        tail[0] = 73;
        rstn[0] = 1'b1;
        rdy[0]  = 1'b1;
        tick();
        chk("mid_refill_valid", 32'(mv[0]), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("mid_refill_data", md[0], 32'(300 + k));
            chk("mid_refill_last", 32'(ml[0]), 32'(k == 15));
        end

        // Random stall, latency 0, random refill
        rstn[1] = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 200 && cyc < 3000) begin
            tick();
            cyc++;
            if (tail[1] < 200) begin
                tail[1] = tail[1] + $urandom_range(0, 2);
                if (tail[1] > 200) tail[1] = 200;
            end
            rdy[1] = 1'($urandom_range(0, 1));
            #1;
            chk("rand_no_underflow", 32'(so[1] & emp[1]), 32'd0);
            if (mv[1] && rdy[1]) begin
                chk("rand_order", md[1], 32'(got * 3 + 7));
                got++;
            end
        end
        chk("rand_count", 32'(got), 32'd200);
        chk("rand_overrun", 32'(ovr[1]), 32'd0);

        // Latency-0 drain on a latency-1 FIFO with the consumer stalled
        rstn[2] = 1'b1;
        tick();
        tick();
        tick();
        chk("mis_pre_ovr", 32'(ovr[2]), 32'd0);
        chk("mis_valid", 32'(mv[2]), 32'd1);
        chk("mis_data", md[2], 32'hA0);
        tick();
        chk("mis_ovr_set", 32'(ovr[2]), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("mis_ovr_sticky", 32'(ovr[2]), 32'd1);
        chk("mis_data_hold", md[2], 32'hA0);

        // Burst length 1
        rdy[3]  = 1'b1;
        rstn[3] = 1'b1;
        tick();
        chk("b1_lat_valid", 32'(mv[3]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("b1_data", md[3], 32'(50 + k));
            chk("b1_last", 32'(ml[3]), 32'd1);
            chk("b1_cnt", bc[3], 32'd0);
        end
        tick();
        chk("b1_end_valid", 32'(mv[3]), 32'd0);
        chk("b1_end_last", 32'(ml[3]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
